door_sequencer: RTL and testbench
=================================

Name: door_sequencer

Overview:
- Autonomous open/hold/close sequencer for the SG-90 door servo on the 100 MHz board.
- Turns open/close button requests and an obstruction sensor into a ramped servo position.
- Generates the servo PWM itself through one sub-module, so the door runs a full cycle from a single button press instead of needing the button held.
- Sits between the board buttons/sensor and the JA servo pin.

Parameters:
FRAME_CYCLES, 2000000, PWM frame length in clk cycles (20 ms)
MIN_PULSE, 100000, pulse width at position 0 (1 ms, door closed)
TRAVEL, 100000, position span; pulse = MIN_PULSE + pos (2 ms max, door open)
STEP, 500, position change per frame while moving
HOLD_FRAMES, 150, frames held open before auto-close (3 s)

Ports:
clk  input  1  100 MHz system clock
rst  input  1  synchronous active-high reset
btnL  input  1  raw open button, asynchronous
btnR  input  1  raw close button, asynchronous
obstruct  input  1  raw obstruction sensor, high = blocked, asynchronous
JA  output  1  servo PWM
state  output  2  0 CLOSED, 1 OPENING, 2 OPEN_HOLD, 3 CLOSING
busy  output  1  high in OPENING or CLOSING

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: counter=0, pos=0, hold_cnt=0, pending flags=0, state=CLOSED, JA=0, busy=0. Reset mid-motion abandons the move; the servo is commanded closed (pos 0) from the next frame.
- Inputs: each input passes through a 2-FF synchronizer. A rising edge of a synced button sets sticky flag open_req or close_req. Both flags clear at every frame_tick after evaluation. Bounce therefore yields one request.
- Frame counter: 0..FRAME_CYCLES-1, wraps to 0. frame_tick = (counter == FRAME_CYCLES-1).
- PWM output: JA is registered and equals (counter < MIN_PULSE+pos), i.e. one cycle latency. pos changes only at frame_tick, so every frame has a clean width.
- Transitions are evaluated at frame_tick only, except obstruction (see below). Precedence when both flags are set: open wins.
  - CLOSED: open_req -> OPENING. close_req is ignored.
  - OPENING: pos <= min(pos+STEP, TRAVEL), saturating. When the new pos == TRAVEL -> OPEN_HOLD with hold_cnt=0. close_req is ignored.
  - OPEN_HOLD: hold_cnt++. Transitions:
    - open_req restarts the hold (hold_cnt=0).
    - close_req -> CLOSING immediately.
    - hold_cnt == HOLD_FRAMES-1 -> CLOSING.
    - Synced obstruct high blocks the transition to CLOSING and holds hold_cnt at 0.
  - CLOSING: pos <= max(pos-STEP, 0), saturating. When the new pos == 0 -> CLOSED. open_req -> OPENING, and pos is not decremented that tick.
- Obstruction override: synced obstruct high in CLOSING switches state to OPENING on the next clk, not at the frame tick. pos stays frozen until the next frame_tick, which increments it.
- Widths: pos and compare use 18 bits (MIN_PULSE+TRAVEL ≤ 2^18). Counter uses 21 bits.
- busy is combinational from the state register.

Decomposition:
- Package door_pkg holds:
  - the state encoding constants (ST_CLOSED, ST_OPENING, ST_OPEN_HOLD, ST_CLOSING);
  - the default timing constants.
- Sub-module servo_pwm (params FRAME_CYCLES, MIN_PULSE):
  - ports: clk, rst, pos in, pwm out, frame_tick out;
  - contains the frame counter and the registered compare.
- door_sequencer contains the synchronizers, request flags, the FSM and the pos/hold registers.

Test Plan:
All scenarios use FRAME_CYCLES=100, MIN_PULSE=10, TRAVEL=40, STEP=10, HOLD_FRAMES=3.
1. Reset, no input -> JA high exactly 10 cycles per 100-cycle frame; state=0, busy=0.
2. 1-cycle btnL pulse in CLOSED -> OPENING at the next tick. Frame widths 20,30,40,50 follow. state=2 after pos reaches 40; 3 frames later state=3. Widths 40,30,20,10 follow, then state=0.
3. btnL with 5 bounce edges within one frame -> single request; same sequence as scenario 2, no double step.
4. obstruct asserted 2 cycles after entering CLOSING at pos=30 -> state=1 within 3 clk; the next frame width is 50, and the door reopens and holds.
5. btnL and btnR pulsed in the same frame while CLOSED -> OPENING (open wins). btnR during OPEN_HOLD -> CLOSING at the next tick without waiting 3 frames.
6. rst asserted mid-OPENING at pos=20 -> the next cycle has state=0, pos=0, JA=0; the first frame after release has width 10.

Source files
------------

// File: rtl/door_pkg.sv
// door_pkg: state encoding and default timing for the door servo sequencer
package door_pkg;
    typedef enum logic [1:0] {
        ST_CLOSED    = 2'd0,
        ST_OPENING   = 2'd1,
        ST_OPEN_HOLD = 2'd2,
        ST_CLOSING   = 2'd3
    } state_t;
    localparam int FRAME_CYCLES_DEF = 2000000;
    localparam int MIN_PULSE_DEF    = 100000;
    localparam int TRAVEL_DEF       = 100000;
    localparam int STEP_DEF         = 500;
    localparam int HOLD_FRAMES_DEF  = 150;
    localparam int POS_W            = 18;
    localparam int CNT_W            = 21;
endpackage

// File: rtl/door_sequencer_servo_pwm.sv
// servo_pwm: frame counter and registered pulse-width compare for the servo
module servo_pwm
    import door_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int MIN_PULSE    = MIN_PULSE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] pos_i,
    output logic             pwm_o,
    output logic             frame_tick_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] thr;
    logic             pwm_q, pwm_d;
    assign thr          = POS_W'(MIN_PULSE) + pos_i;
    assign frame_tick_o = cnt_q == CNT_W'(FRAME_CYCLES - 1);
    assign cnt_d        = frame_tick_o ? '0 : cnt_q + CNT_W'(1);
    assign pwm_d        = cnt_q < CNT_W'(thr);
    assign pwm_o        = pwm_q;
    // free-running frame counter and one-cycle-late pulse compare
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end
endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: button/obstruction driven open-hold-close servo sequencer
module door_sequencer
    import door_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int MIN_PULSE    = MIN_PULSE_DEF,
    parameter int TRAVEL       = TRAVEL_DEF,
    parameter int STEP         = STEP_DEF,
    parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       obstruct,
    output logic       JA,
    output logic [1:0] state,
    output logic       busy
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [POS_W-1:0] TRAVEL_P = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
    // bit 0/1 are the synchronizer stages, bit 2 the previous synced value for edge detect
    logic [2:0]       l_sync_q, r_sync_q;
    logic [1:0]       ob_sync_q;
    logic             open_req_q, open_req_d, close_req_q, close_req_d;
    logic             rise_l, rise_r, ob, tick;
    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, pos_up, pos_dn;
    logic [HW-1:0]    hold_q, hold_d;
    assign rise_l      = l_sync_q[1] & ~l_sync_q[2];
    assign rise_r      = r_sync_q[1] & ~r_sync_q[2];
    assign ob          = ob_sync_q[1];
    assign open_req_d  = tick ? rise_l : (open_req_q | rise_l);
    assign close_req_d = tick ? rise_r : (close_req_q | rise_r);
    assign pos_up      = (pos_q + STEP_P >= TRAVEL_P) ? TRAVEL_P : pos_q + STEP_P;
    assign pos_dn      = (pos_q <= STEP_P) ? '0 : pos_q - STEP_P;
    assign state       = state_q;
    assign busy        = (state_q == ST_OPENING) || (state_q == ST_CLOSING);
    servo_pwm #(
        .FRAME_CYCLES(FRAME_CYCLES),
        .MIN_PULSE   (MIN_PULSE)
    ) u_pwm (
        .clk         (clk),
        .rst         (rst),
        .pos_i       (pos_q),
        .pwm_o       (JA),
        .frame_tick_o(tick)
    );
    // input synchronizers and sticky request flags, cleared each frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            l_sync_q    <= '0;
            r_sync_q    <= '0;
            ob_sync_q   <= '0;
            open_req_q  <= 1'b0;
            close_req_q <= 1'b0;
        end else begin
            l_sync_q    <= {l_sync_q[1:0], btnL};
            r_sync_q    <= {r_sync_q[1:0], btnR};
            ob_sync_q   <= {ob_sync_q[0], obstruct};
            open_req_q  <= open_req_d;
            close_req_q <= close_req_d;
        end
    end
    // state, position and hold-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLOSED;
            pos_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
        end
    end
    // next state: frame-tick transitions, plus the immediate obstruction reversal while closing
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        case (state_q)
            ST_CLOSED: begin
                if (tick && open_req_q) state_d = ST_OPENING;
            end
            ST_OPENING: begin
                if (tick) begin
                    pos_d  = pos_up;
                    hold_d = '0;
                    if (pos_up == TRAVEL_P) state_d = ST_OPEN_HOLD;
                end
            end
            ST_OPEN_HOLD: begin
                if (tick) begin
                    if (ob || open_req_q) hold_d = '0;
                    else if (close_req_q || hold_q == HW'(HOLD_FRAMES - 1)) state_d = ST_CLOSING;
                    else hold_d = hold_q + HW'(1);
                end
            end
            ST_CLOSING: begin
                if (ob) state_d = ST_OPENING;
                else if (tick) begin
                    if (open_req_q) state_d = ST_OPENING;
                    else begin
                        pos_d = pos_dn;
                        if (pos_dn == '0) state_d = ST_CLOSED;
                    end
                end
            end
            default: state_d = ST_CLOSED;
        endcase
    end
endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer: frame-level randomized check of door_sequencer against a spec model
module tb_door_sequencer;
    localparam int FC = 100, MP = 10, TR = 40, SP = 10, HF = 3;
    logic       clk = 1'b0, rst = 1'b1, btnL = 1'b0, btnR = 1'b0, obstruct = 1'b0;
    logic       JA, busy;
    logic [1:0] state;
    int         n_tests = 0, n_fail = 0;
    int         m_st = 0, m_pos = 0, m_hold = 0;
    bit [2:0]   dir [10];
    bit         rl, rr, rob;
    always #5 clk = ~clk;
    door_sequencer #(
        .FRAME_CYCLES(FC),
        .MIN_PULSE   (MP),
        .TRAVEL      (TR),
        .STEP        (SP),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btnL    (btnL),
        .btnR    (btnR),
        .obstruct(obstruct),
        .JA      (JA),
        .state   (state),
        .busy    (busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        btnL = 1'b0;
        btnR = 1'b0;
        obstruct = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_JA", 32'(JA), 0);
        m_st = 0;
        m_pos = 0;
        m_hold = 0;
    endtask
    // one PWM frame starting at counter 0: drive buttons (with bounce) and obstruct, measure width, then apply the tick rules
    task automatic run_frame(input bit l, input bit r, input bit ob, input int stop_at = FC);
        int sl, nl, sr, nr, hi, mid;
        sl = $urandom_range(15, 50);
        nl = $urandom_range(1, 5);
        sr = $urandom_range(15, 50);
        nr = $urandom_range(1, 5);
        hi = 0;
        mid = (m_st == 3 && ob) ? 1 : m_st;
        for (int o = 0; o < stop_at; o++) begin
            btnL = l && o >= sl && o < sl + 2 * nl && ((o - sl) % 2 == 0);
            btnR = r && o >= sr && o < sr + 2 * nr && ((o - sr) % 2 == 0);
            if (o == 5) obstruct = ob;
            @(negedge clk);
            hi += int'(JA);
            if (o == 2) begin
                check("state_start", 32'(state), m_st);
                check("busy", 32'(busy), (m_st == 1 || m_st == 3) ? 1 : 0);
            end
            if (o == 95) check("state_mid", 32'(state), mid);
            @(posedge clk);
            #1;
        end
        btnL = 1'b0;
        btnR = 1'b0;
        if (stop_at == FC) begin
            check("width", hi, MP + m_pos);
            m_st = mid;
            if (m_st == 0) begin
                if (l) m_st = 1;
            end else if (m_st == 1) begin
                m_pos = (m_pos + SP > TR) ? TR : m_pos + SP;
                if (m_pos == TR) begin
                    m_st = 2;
                    m_hold = 0;
                end
            end else if (m_st == 2) begin
                if (ob || l) m_hold = 0;
                else if (r || m_hold == HF - 1) m_st = 3;
                else m_hold++;
            end else begin
                if (l) m_st = 1;
                else begin
                    m_pos = (m_pos < SP) ? 0 : m_pos - SP;
                    if (m_pos == 0) m_st = 0;
                end
            end
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        dir = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000};
        do_reset();
        run_frame(0, 0, 0);
        run_frame(0, 1, 0);
        foreach (dir[i]) run_frame(dir[i][2], dir[i][1], dir[i][0]);
        repeat (60) begin
            rl = $urandom_range(0, 3) == 0;
            rr = $urandom_range(0, 3) == 0;
            rob = $urandom_range(0, 5) == 0;
            run_frame(rl, rr, rob);
        end
        do_reset();
        run_frame(1, 0, 0);
        run_frame(0, 0, 0);
        run_frame(0, 0, 0);
        run_frame(0, 0, 0, 15);
        do_reset();
        run_frame(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
